// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register: operation codes,
// controller state encoding and a small op classification helper.
// Optional compare stage in univ_shift_reg is enabled by UNIV_SHIFT_CMP_EN.
package shift_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_SHR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Shift/rotate ops are the only ones that take stepping cycles.
  function automatic logic is_step_op(input logic [2:0] op);
    return (op != OP_NOP) && (op != OP_LOAD) && (op != OP_CLR);
  endfunction

endpackage

// File: rtl/usr_step.sv
// Single bit-step of the universal shift register: given the current word,
// the operation and the serial inputs, produce the next word and the bit
// that falls out. Purely combinational.
module usr_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic             sl_i,
  input  logic             sr_i,
  output logic [WIDTH-1:0] q_next_o,
  output logic             carry_next_o
);

  // One-step next value; non-stepping ops pass the word through.
  always_comb begin
    q_next_o     = q_i;
    carry_next_o = 1'b0;
    case (op_i)
      OP_SHL: begin
        q_next_o     = {q_i[WIDTH-2:0], sl_i};
        carry_next_o = q_i[WIDTH-1];
      end
      OP_SHR: begin
        q_next_o     = {sr_i, q_i[WIDTH-1:1]};
        carry_next_o = q_i[0];
      end
      OP_ROL: begin
        q_next_o     = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
        carry_next_o = q_i[WIDTH-1];
      end
      OP_ROR: begin
        q_next_o     = {q_i[0], q_i[WIDTH-1:1]};
        carry_next_o = q_i[0];
      end
      OP_ASR: begin
        q_next_o     = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
        carry_next_o = q_i[0];
      end
      default: begin
        q_next_o     = q_i;
        carry_next_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load, clear, shifts and rotates by a
// programmable count, one bit-step per clock under start/busy/done.
// Define UNIV_SHIFT_CMP_EN to add the cmp_i / eq_o / gr_o / le_o compare stage.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | waiting for start_i; single-cycle ops complete here
//   ST_RUN  | stepping op_q once per clock until cnt_q reaches terminal 1
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int AMT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [AMT_W-1:0] amt_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             sl_i,
  input  logic             sr_i,
  output logic [WIDTH-1:0] q_o,
  output logic             carry_o,
  output logic             busy_o,
`ifdef UNIV_SHIFT_CMP_EN
  input  logic [WIDTH-1:0] cmp_i,
  output logic             eq_o,
  output logic             gr_o,
  output logic             le_o,
`endif
  output logic             done_o
);

  logic [0:0]       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             carry_q, carry_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] step_q;
  logic             step_carry;

  usr_step #(.WIDTH(WIDTH)) u_step (
    .op_i         (op_q),
    .q_i          (q_q),
    .sl_i         (sl_i),
    .sr_i         (sr_i),
    .q_next_o     (step_q),
    .carry_next_o (step_carry)
  );

  // Command decode, step sequencing and down-counter terminal compare.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (is_step_op(op_i) && (amt_i != '0)) begin
            op_d    = op_i;
            cnt_d   = amt_i;
            state_d = ST_RUN;
          end else begin
            // Zero-count shifts complete like a NOP.
            done_d = 1'b1;
            if (op_i == OP_LOAD) q_d = d_i;
            else if (op_i == OP_CLR) q_d = '0;
          end
        end
      end
      ST_RUN: begin
        q_d     = step_q;
        carry_d = step_carry;
        cnt_d   = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      cnt_q   <= '0;
      q_q     <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      carry_q <= carry_d;
      done_q  <= done_d;
    end
  end

  assign q_o     = q_q;
  assign carry_o = carry_q;
  assign busy_o  = (state_q == ST_RUN);
  assign done_o  = done_q;

`ifdef UNIV_SHIFT_CMP_EN
  // Unsigned magnitude compare of the live register against cmp_i.
  always_comb begin
    eq_o = (q_q == cmp_i);
    gr_o = (q_q > cmp_i);
    le_o = (q_q < cmp_i);
  end
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8). Compare-stage checks
// are included when UNIV_SHIFT_CMP_EN is defined.
module tb_univ_shift_reg;

  localparam int W = 8;
  localparam int AW = 4;

  localparam logic [2:0] NOP = 3'b000, LOAD = 3'b001, SHL = 3'b010, SHR = 3'b011,
                         ROL = 3'b100, ROR = 3'b101, ASR = 3'b110, CLR = 3'b111;

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b0;
  logic          start_i = 1'b0;
  logic [2:0]    op_i = 3'b000;
  logic [AW-1:0] amt_i = '0;
  logic [W-1:0]  d_i = '0;
  logic          sl_i = 1'b0;
  logic          sr_i = 1'b0;
  logic [W-1:0]  q_o;
  logic          carry_o, busy_o, done_o;
`ifdef UNIV_SHIFT_CMP_EN
  logic [W-1:0]  cmp_i = '0;
  logic          eq_o, gr_o, le_o;
`endif

  int n_chk = 0;
  int n_fail = 0;

  univ_shift_reg #(.WIDTH(W)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .start_i (start_i),
    .op_i    (op_i),
    .amt_i   (amt_i),
    .d_i     (d_i),
    .sl_i    (sl_i),
    .sr_i    (sr_i),
    .q_o     (q_o),
    .carry_o (carry_o),
    .busy_o  (busy_o),
`ifdef UNIV_SHIFT_CMP_EN
    .cmp_i   (cmp_i),
    .eq_o    (eq_o),
    .gr_o    (gr_o),
    .le_o    (le_o),
`endif
    .done_o  (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic is_step(input logic [2:0] op);
    return op inside {SHL, SHR, ROL, ROR, ASR};
  endfunction

  // Reference: result of n shifts computed in one go as a wide arithmetic
  // shift of the word concatenated with its incoming bit stream.
  // Returns {carry, q}. slb/srb bit i is the serial value at step i.
  function automatic logic [W:0] model(input logic [2:0] op, input int n,
                                       input logic [W-1:0] q, input logic c,
                                       input logic [15:0] slb, input logic [15:0] srb);
    logic [63:0] full;
    logic [63:0] qq;
    logic [W-1:0] r;
    int k;
    qq = 64'(q);
    if (!is_step(op) || n == 0) return {c, q};
    case (op)
      SHL: begin
        full = qq << n;
        for (int i = 0; i < n; i++) full[n-1-i] = slb[i];
        return {full[W], full[W-1:0]};
      end
      SHR, ASR: begin
        full = qq;
        for (int i = 0; i < n; i++) full[W+i] = (op == ASR) ? q[W-1] : srb[i];
        r = W'(full >> n);
        return {full[n-1], r};
      end
      ROL: begin
        k = n % W;
        r = W'((qq << k) | (qq >> (W - k)));
        return {r[0], r};
      end
      default: begin
        k = n % W;
        r = W'((qq >> k) | (qq << (W - k)));
        return {r[W-1], r};
      end
    endcase
  endfunction

  // Issue one command at the current negedge, step it through, and end on the
  // negedge where done_o should be high.
  task automatic exec(input string name, input logic [2:0] op, input logic [AW-1:0] amt,
                      input logic [W-1:0] d, input logic [15:0] slb, input logic [15:0] srb,
                      input logic [W-1:0] exp_q, input logic exp_c);
    int steps;
    steps = (is_step(op) && amt != 0) ? int'(amt) : 0;
    start_i = 1'b1; op_i = op; amt_i = amt; d_i = d;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    op_i = 3'($urandom); amt_i = AW'($urandom); d_i = W'($urandom);
    for (int i = 0; i < steps; i++) begin
      sl_i = slb[i]; sr_i = srb[i];
      @(negedge clk_i);
      chk({name, " busy"}, busy_o, 1);
      chk({name, " done_early"}, done_o, 0);
      @(posedge clk_i); #1;
    end
    @(negedge clk_i);
    chk({name, " q"}, q_o, exp_q);
    chk({name, " carry"}, carry_o, exp_c);
    chk({name, " done"}, done_o, 1);
    chk({name, " busy_end"}, busy_o, 0);
  endtask

  typedef struct {
    logic [2:0]    op;
    logic [AW-1:0] amt;
    logic [W-1:0]  d;
    logic          sl;
    logic          sr;
    logic [W-1:0]  exp_q;
    logic          exp_c;
  } vec_t;

  vec_t tbl[11];
  logic [W-1:0] mq;
  logic         mc;
  logic [W:0]   m;
  logic [15:0]  slb, srb;
  logic [2:0]   rop;
  logic [AW-1:0] ramt;
  logic [W-1:0] rd;

  initial begin
    tbl[0]  = '{LOAD, 4'd0, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0};
    tbl[1]  = '{SHL,  4'd3, 8'h00, 1'b1, 1'b0, 8'h2F, 1'b1};
    tbl[2]  = '{LOAD, 4'd0, 8'h90, 1'b0, 1'b0, 8'h90, 1'b1};
    tbl[3]  = '{ASR,  4'd2, 8'h00, 1'b0, 1'b1, 8'hE4, 1'b0};
    tbl[4]  = '{LOAD, 4'd0, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0};
    tbl[5]  = '{ROR,  4'd9, 8'h00, 1'b0, 1'b0, 8'hC0, 1'b1};
    tbl[6]  = '{NOP,  4'd0, 8'h55, 1'b0, 1'b0, 8'hC0, 1'b1};
    tbl[7]  = '{ROL,  4'd0, 8'h55, 1'b1, 1'b1, 8'hC0, 1'b1};
    tbl[8]  = '{SHR,  4'd4, 8'h00, 1'b0, 1'b0, 8'h0C, 1'b0};
    tbl[9]  = '{ROL,  4'd5, 8'h00, 1'b0, 1'b0, 8'h81, 1'b1};
    tbl[10] = '{CLR,  4'd0, 8'h77, 1'b0, 1'b0, 8'h00, 1'b1};

    // Reset values, while reset is held and after release with no start.
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst q", q_o, 0);
    chk("rst carry", carry_o, 0);
    chk("rst busy", busy_o, 0);
    chk("rst done", done_o, 0);
    @(negedge clk_i); rst_n_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      chk("idle q", q_o, 0);
      chk("idle done", done_o, 0);
      chk("idle busy", busy_o, 0);
    end

    // Directed table, back-to-back on done cycles.
    for (int i = 0; i < 11; i++)
      exec($sformatf("tbl%0d", i), tbl[i].op, tbl[i].amt, tbl[i].d,
           {16{tbl[i].sl}}, {16{tbl[i].sr}}, tbl[i].exp_q, tbl[i].exp_c);

    // Done is a single pulse.
    @(negedge clk_i);
    chk("done single", done_o, 0);

`ifdef UNIV_SHIFT_CMP_EN
    exec("cmp load", LOAD, 4'd0, 8'hA5, 16'h0, 16'h0, 8'hA5, 1'b1);
    cmp_i = 8'hA5; #1;
    chk("cmp eq", {eq_o, gr_o, le_o}, 3'b100);
    cmp_i = 8'h10; #1;
    chk("cmp gr", {eq_o, gr_o, le_o}, 3'b010);
    cmp_i = 8'hF0; #1;
    chk("cmp le", {eq_o, gr_o, le_o}, 3'b001);
    @(negedge clk_i);
`endif

    // Start pulsed mid-run with LOAD FF must be ignored.
    exec("pre mid", LOAD, 4'd0, 8'hA5, 16'h0, 16'h0, 8'hA5, 1'b1);
    start_i = 1'b1; op_i = SHL; amt_i = 4'd6; sl_i = 1'b0;
    @(posedge clk_i); #1;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin start_i = 1'b1; op_i = LOAD; d_i = 8'hFF; end
      else start_i = 1'b0;
      @(posedge clk_i); #1;
    end
    start_i = 1'b0;
    @(negedge clk_i);
    chk("mid q", q_o, 8'h40);
    chk("mid carry", carry_o, 1);
    chk("mid done", done_o, 1);
    @(negedge clk_i);
    chk("mid done drop", done_o, 0);
    chk("mid q hold", q_o, 8'h40);

    // Reset mid-run: immediate clear, no done pulse afterwards.
    start_i = 1'b1; op_i = ROL; amt_i = 4'd10;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_n_i = 1'b0;
    #1;
    chk("rstrun q", q_o, 0);
    chk("rstrun carry", carry_o, 0);
    chk("rstrun busy", busy_o, 0);
    chk("rstrun done", done_o, 0);
    @(negedge clk_i); rst_n_i = 1'b1;
    repeat (12) begin
      @(negedge clk_i);
      chk("post rst done", done_o, 0);
    end

    // Randomized commands against the reference model.
    mq = '0; mc = 1'b0;
    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom);
      ramt = AW'($urandom_range(0, 15));
      rd = W'($urandom);
      slb = 16'($urandom); srb = 16'($urandom);
      if (rop == LOAD) m = {mc, rd};
      else if (rop == CLR) m = {mc, {W{1'b0}}};
      else m = model(rop, int'(ramt), mq, mc, slb, srb);
      exec($sformatf("rnd%0d op%0d n%0d", i, rop, ramt), rop, ramt, rd, slb, srb, m[W-1:0], m[W]);
`ifdef UNIV_SHIFT_CMP_EN
      cmp_i = W'($urandom); #1;
      chk("rnd cmp", {eq_o, gr_o, le_o},
          {m[W-1:0] == cmp_i, m[W-1:0] > cmp_i, m[W-1:0] < cmp_i});
`endif
      mq = m[W-1:0]; mc = m[W];
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register: WIDTH-bit register with parallel load, clear, logical/arithmetic shifts and rotates by a programmable count, executed one bit-step per clock under a start/busy/done handshake. Serial inputs are sampled on every step, so the block also serves as SIPO/SISO/PISO. It is the general-purpose shift/rotate datapath element of the shift-register library. An optional compare stage flags q_o against a reference word.

## Interface
- WIDTH, 8, register width (>= 2)
- AMT_W, $clog2(WIDTH+1), shift-count width (derived; not overridden)

- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- start_i  in  1  command strobe, accepted only in IDLE
- op_i  in  3  operation: 000 NOP, 001 LOAD, 010 SHL, 011 SHR, 100 ROL, 101 ROR, 110 ASR, 111 CLR
- amt_i  in  AMT_W  shift count, unsigned
- d_i  in  WIDTH  parallel load data
- sl_i  in  1  serial in for SHL (enters bit 0)
- sr_i  in  1  serial in for SHR (enters bit WIDTH-1)
- q_o  out  WIDTH  register contents
- carry_o  out  1  bit shifted/rotated out on the most recent step
- busy_o  out  1  multi-step operation in progress
- done_o  out  1  one-cycle completion pulse
- cmp_i / eq_o / gr_o / le_o: see Configuration

## Operation
- Reset: q_o=0, carry_o=0, busy_o=0, done_o=0, state IDLE.
- States: IDLE, RUN. Registered op and down-counter cnt.
- IDLE, start_i=1, op in {NOP, LOAD, CLR}: q_o<=d_i (LOAD), 0 (CLR), unchanged (NOP); carry_o unchanged; done_o=1 next cycle; stays IDLE.
- IDLE, start_i=1, shift/rotate op, amt_i=0: treated as NOP (done pulse, no change).
- IDLE, start_i=1, shift/rotate op, amt_i=n>0: latch op, cnt<=n, go RUN; q_o unchanged on this edge.
- RUN: each edge applies one step, cnt<=cnt-1; on step with cnt==1 go IDLE, done_o=1.
- Step rules: SHL q<={q[W-2:0],sl_i}, carry=q[W-1]; SHR q<={sr_i,q[W-1:1]}, carry=q[0]; ROL q<={q[W-2:0],q[W-1]}, carry=q[W-1]; ROR q<={q[0],q[W-1:1]}, carry=q[0]; ASR q<={q[W-1],q[W-1:1]}, carry=q[0].
- sl_i/sr_i sampled at each step edge (streaming input).
- amt_i > WIDTH allowed: steps continue (SHL/SHR fill with serial input, ASR with sign, rotates wrap modulo WIDTH).
- start_i ignored while busy_o=1; op_i/amt_i/d_i changes during RUN have no effect.
- Reset asserted mid-RUN: immediate return to reset values; no done_o pulse.

## Timing
- Start accepted at edge k. Single-cycle ops: q_o valid after edge k, done_o high for cycle after k, busy_o never asserted.
- Shift of n: busy_o high from after edge k through edge k+n (n cycles); final q_o and carry_o valid after edge k+n; done_o high for cycle after k+n, coincident with busy_o=0.
- Back-to-back: start_i may be accepted on the same cycle done_o is high (state is IDLE).
- All outputs registered except compare flags.

## Configuration
- Macro UNIV_SHIFT_CMP_EN.
- Defined: adds cmp_i (in, WIDTH) and eq_o, gr_o, le_o (out, 1); combinational unsigned compare of q_o vs cmp_i: gr_o=q_o>cmp_i, eq_o=q_o==cmp_i, le_o=q_o<cmp_i; exactly one high at all times; after reset q_o=0 so eq_o=1 iff cmp_i=0.
- Undefined: those ports and logic absent; all other behaviour identical.

## Structure
- Package shift_pkg: op codes (OP_NOP..OP_CLR), state encoding (ST_IDLE, ST_RUN).
- Sub-module usr_step: combinational single-step next-value and carry function (op, q, sl, sr -> q_next, carry_next), instanced once.
- Top holds FSM, counter, registers, optional comparator.

## Test plan
- Reset with WIDTH=8: q_o=8'h00, carry_o=0, busy_o=0, done_o=0; release, no activity without start_i.
- LOAD d_i=8'hA5 -> q_o=8'hA5 after one edge, done_o one cycle, busy_o stays 0.
- From 8'hA5, SHL amt=3, sl_i=1 -> busy_o 3 cycles, q_o=8'h2F, carry_o=1, single done_o pulse.
- From 8'h90, ASR amt=2 -> q_o=8'hE4, carry_o=0; from 8'h81, ROR amt=9 -> q_o=8'hC0, carry_o=1 after 9 steps.
- start_i pulsed mid-run with LOAD 8'hFF -> ignored; rst_n_i low mid-run -> q_o=00 immediately, no done_o.
- With UNIV_SHIFT_CMP_EN: q_o=8'hA5, cmp_i=8'hA5 -> eq_o=1; cmp_i=8'h10 -> gr_o=1; cmp_i=8'hF0 -> le_o=1.
